// File: rtl/off_board_pkg.sv
// Shared definitions for the off-board word link framing (decode and encode sides).
// Holds the sync pattern, the deframer state encoding and the header validity rule.
package off_board_pkg;

  localparam logic [15:0] OB_SYNC = 16'hA5A5;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } ob_dec_state_t;

  // A header is valid when the sync matches and the length is 1..max_len.
  function automatic logic ob_hdr_ok(input logic [31:0] word, input logic [16:0] max_len);
    return (word[31:16] == OB_SYNC) && (word[15:0] != 16'd0) &&
           ({1'b0, word[15:0]} <= max_len);
  endfunction

endpackage

// File: rtl/off_board_sat_cnt.sv
// Saturating up-counter: stops at all-ones instead of wrapping.
module off_board_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/off_board_decode.sv
// Receive-side deframer: hunts for a sync/length header, forwards payload cut-through
// with a last marker, and checks the trailing mod-2^32 checksum.
module off_board_decode
  import off_board_pkg::*;
#(
  parameter int MAX_LEN = 256,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      t0_data,
  input  logic             t0_valid,
  output logic             t0_ready,
  output logic [31:0]      i0_data,
  output logic             i0_valid,
  output logic             i0_last,
  input  logic             i0_ready,
  output logic             frame_ok,
  output logic             frame_err,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam logic [16:0] MAX_LEN_L = 17'(MAX_LEN);

  ob_dec_state_t state_reg, state_next;
  logic [31:0]   sum_reg;
  logic [15:0]   remaining_reg;

  logic          accept;
  logic          hdr_ok;
  logic          sum_match;
  logic          load_hdr;
  logic          load_pay;
  logic          drop_inc;
  logic          check_acc;
  logic [2:0]    cnt_inc;
  logic [CNT_W-1:0] cnt_val [3];

  assign hdr_ok    = ob_hdr_ok(t0_data, MAX_LEN_L);
  assign sum_match = (t0_data == sum_reg);
  assign accept    = t0_valid && t0_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= HUNT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      HUNT:    if (accept && hdr_ok) state_next = PAYLOAD;
      PAYLOAD: if (accept && (remaining_reg == 16'd1)) state_next = CHECK;
      CHECK:   if (accept) state_next = HUNT;
      default: state_next = HUNT;
    endcase
  end

  // Backpressure only applies in PAYLOAD; header and checksum words never reach the output register.
  always_comb begin
    t0_ready  = 1'b1;
    load_hdr  = 1'b0;
    load_pay  = 1'b0;
    drop_inc  = 1'b0;
    check_acc = 1'b0;
    case (state_reg)
      HUNT: begin
        load_hdr = t0_valid && hdr_ok;
        drop_inc = t0_valid && !hdr_ok;
      end
      PAYLOAD: begin
        t0_ready = !i0_valid || i0_ready;
        load_pay = t0_valid && t0_ready;
      end
      CHECK: begin
        check_acc = t0_valid;
      end
      default: begin
        t0_ready = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_reg       <= '0;
      remaining_reg <= '0;
      i0_data       <= '0;
      i0_valid      <= 1'b0;
      i0_last       <= 1'b0;
      frame_ok      <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      frame_ok  <= check_acc && sum_match;
      frame_err <= check_acc && !sum_match;
      if (load_hdr) begin
        remaining_reg <= t0_data[15:0];
        sum_reg       <= t0_data;
      end
      if (load_pay) begin
        remaining_reg <= remaining_reg - 16'd1;
        sum_reg       <= sum_reg + t0_data;
        i0_data       <= t0_data;
        i0_valid      <= 1'b1;
        i0_last       <= (remaining_reg == 16'd1);
      end else if (i0_ready) begin
        i0_valid <= 1'b0;
      end
    end
  end

  assign cnt_inc[0] = check_acc && sum_match;
  assign cnt_inc[1] = check_acc && !sum_match;
  assign cnt_inc[2] = drop_inc;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      off_board_sat_cnt #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (cnt_inc[gi]),
        .count (cnt_val[gi])
      );
    end
  endgenerate

  assign good_cnt = cnt_val[0];
  assign bad_cnt  = cnt_val[1];
  assign drop_cnt = cnt_val[2];

endmodule
